// File: rtl/pgm_pkg.sv
// Shared constants and types for the PGM ioctl-to-DDRAM ROM load path.
package pgm_pkg;

   localparam int DDR_AW = 29;
   localparam int DATA_W = 64;
   localparam int BE_W   = 8;
   localparam int LANES  = 4;

   localparam logic [DDR_AW-1:0] DDR_BASE_DEF = 29'h0600_0000;
   localparam int REGION_SHIFT_DEF = 21;
   localparam int NUM_REGIONS_DEF  = 8;

   typedef enum logic [2:0] {
      RGN_PROG   = 3'd0,
      RGN_TILE   = 3'd1,
      RGN_SPR_A  = 3'd2,
      RGN_SPR_B  = 3'd3,
      RGN_SAMPLE = 3'd4
   } pgm_region_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_DONE
   } ldr_state_e;

   function automatic logic [BE_W-1:0] lane_be(input logic [1:0] lane);
      return 8'b11 << {lane, 1'b0};
   endfunction

   function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] lane);
      return 64'hFFFF << {lane, 4'b0};
   endfunction

endpackage

// File: rtl/pgm_word_packer.sv
// Accumulates 16-bit lanes into one 64-bit DDRAM word and hands it
// to the out register when it completes, is displaced, or is flushed.
module pgm_word_packer
   import pgm_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_i,
   input  logic [DDR_AW-1:0] addr_i,
   input  logic [1:0]        lane_i,
   input  logic [15:0]       data_i,
   input  logic              flush_i,
   input  logic              out_free_i,
   output logic              acc_valid_o,
   output logic              push_o,
   output logic [DDR_AW-1:0] push_addr_o,
   output logic [DATA_W-1:0] push_din_o,
   output logic [BE_W-1:0]   push_be_o
);

   logic              acc_v_q, acc_v_d;
   logic              acc_done_q, acc_done_d;
   logic [DDR_AW-1:0] acc_addr_q, acc_addr_d;
   logic [DATA_W-1:0] acc_din_q, acc_din_d;
   logic [BE_W-1:0]   acc_be_q, acc_be_d;

   logic              hit;
   logic [DATA_W-1:0] new_din, mrg_din;
   logic [BE_W-1:0]   new_be, mrg_be;

   // A completed word waiting for the out register never absorbs more lanes.
   assign hit     = acc_v_q && !acc_done_q && (acc_addr_q == addr_i);
   assign new_din = {48'd0, data_i} << {lane_i, 4'b0};
   assign new_be  = lane_be(lane_i);
   assign mrg_din = ((hit ? acc_din_q : '0) & ~lane_mask(lane_i)) | new_din;
   assign mrg_be  = (hit ? acc_be_q : '0) | new_be;

   always_comb begin
      acc_v_d     = acc_v_q;
      acc_done_d  = acc_done_q;
      acc_addr_d  = acc_addr_q;
      acc_din_d   = acc_din_q;
      acc_be_d    = acc_be_q;
      push_o      = 1'b0;
      push_addr_o = acc_addr_q;
      push_din_o  = acc_din_q;
      push_be_o   = acc_be_q;
      if (wr_i) begin
         if (acc_v_q && !hit) begin
            push_o     = 1'b1;
            acc_v_d    = 1'b1;
            acc_done_d = (lane_i == 2'd3);
            acc_addr_d = addr_i;
            acc_din_d  = new_din;
            acc_be_d   = new_be;
         end else if (lane_i == 2'd3) begin
            push_o      = 1'b1;
            push_addr_o = addr_i;
            push_din_o  = mrg_din;
            push_be_o   = mrg_be;
            acc_v_d     = 1'b0;
            acc_done_d  = 1'b0;
         end else begin
            acc_v_d    = 1'b1;
            acc_done_d = 1'b0;
            acc_addr_d = addr_i;
            acc_din_d  = mrg_din;
            acc_be_d   = mrg_be;
         end
      end else if (acc_v_q && (acc_done_q || flush_i) && out_free_i) begin
         push_o     = 1'b1;
         acc_v_d    = 1'b0;
         acc_done_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_v_q    <= 1'b0;
         acc_done_q <= 1'b0;
         acc_addr_q <= '0;
         acc_din_q  <= '0;
         acc_be_q   <= '0;
      end else begin
         acc_v_q    <= acc_v_d;
         acc_done_q <= acc_done_d;
         acc_addr_q <= acc_addr_d;
         acc_din_q  <= acc_din_d;
         acc_be_q   <= acc_be_d;
      end
   end

   assign acc_valid_o = acc_v_q;

endmodule

// File: rtl/pgm_ioctl_ddr_writer.sv
// HPS ioctl download to DDRAM ROM writer: region mapping, out register,
// back-pressure and download sequencing.
module pgm_ioctl_ddr_writer
   import pgm_pkg::*;
#(
   parameter logic [DDR_AW-1:0] DDR_BASE     = DDR_BASE_DEF,
   parameter int                REGION_SHIFT = REGION_SHIFT_DEF,
   parameter int                NUM_REGIONS  = NUM_REGIONS_DEF
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [26:0]       ioctl_addr,
   input  logic [15:0]       ioctl_dout,
   input  logic [7:0]        ioctl_index,
   output logic              ioctl_wait,
   input  logic              ddram_busy,
   output logic              ddram_we,
   output logic [DDR_AW-1:0] ddram_addr,
   output logic [DATA_W-1:0] ddram_din,
   output logic [BE_W-1:0]   ddram_be,
   output logic              load_done,
   output logic              load_err
);

   ldr_state_e        state_q;
   logic              out_v_q, out_v_d;
   logic [DDR_AW-1:0] out_addr_q;
   logic [DATA_W-1:0] out_din_q;
   logic [BE_W-1:0]   out_be_q;
   logic              wait_q, done_q, err_q;

   logic              in_range, wr_live, wr_ok, wr_bad, flush;
   logic [DDR_AW-1:0] word_off, word_addr;
   logic              acc_valid, push;
   logic [DDR_AW-1:0] push_addr;
   logic [DATA_W-1:0] push_din;
   logic [BE_W-1:0]   push_be;

   assign in_range = (ioctl_index < 8'(NUM_REGIONS))
                  && ((ioctl_addr >> (REGION_SHIFT + 3)) == '0);
   assign word_off = 29'(ioctl_addr[26:3])
                   & ((29'd1 << REGION_SHIFT) - 29'd1);
   assign word_addr = DDR_BASE
                    + (29'(ioctl_index[2:0]) << REGION_SHIFT)
                    + word_off;

   assign wr_live = (state_q == S_LOAD) && ioctl_download && ioctl_wr;
   assign wr_ok   = wr_live && in_range && !wait_q;
   assign wr_bad  = wr_live && !wr_ok;
   assign flush   = (state_q == S_DRAIN)
                 || ((state_q == S_LOAD) && !ioctl_download);
   assign out_v_d = push || (out_v_q && ddram_busy);

   pgm_word_packer u_packer (
      .clk_i       (clk_sys),
      .rst_i       (reset),
      .wr_i        (wr_ok),
      .addr_i      (word_addr),
      .lane_i      (ioctl_addr[2:1]),
      .data_i      (ioctl_dout),
      .flush_i     (flush),
      .out_free_i  (!out_v_q),
      .acc_valid_o (acc_valid),
      .push_o      (push),
      .push_addr_o (push_addr),
      .push_din_o  (push_din),
      .push_be_o   (push_be)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= S_IDLE;
         out_v_q    <= 1'b0;
         out_addr_q <= '0;
         out_din_q  <= '0;
         out_be_q   <= '0;
         wait_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         out_v_q <= out_v_d;
         wait_q  <= out_v_d;
         done_q  <= 1'b0;
         if (push) begin
            out_addr_q <= push_addr;
            out_din_q  <= push_din;
            out_be_q   <= push_be;
         end
         if (wr_bad) err_q <= 1'b1;
         unique case (state_q)
            S_IDLE: begin
               if (ioctl_download) begin
                  err_q   <= 1'b0;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (!ioctl_download) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!acc_valid && !out_v_q) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ioctl_wait = wait_q;
   assign ddram_we   = out_v_q;
   assign ddram_addr = out_addr_q;
   assign ddram_din  = out_din_q;
   assign ddram_be   = out_be_q;
   assign load_done  = done_q;
   assign load_err   = err_q;

endmodule

// File: doc/pgm_ioctl_ddr_writer.md
Name: pgm_ioctl_ddr_writer

Overview:
- Sits between the HPS ioctl download stream and the DDRAM write port inside the PGM core; it is the ROM-load path that feeds the DDRAM used by the 68k/Z80/video fetchers.
- Packs sequential 16-bit ioctl words into 64-bit single-beat DDRAM writes with byte enables.
- Maps ioctl_index to a fixed DDRAM region and back-pressures the HPS through ioctl_wait while a write is outstanding.
- Flushes partial words at end of download and pulses load_done.

Parameters:
- DDR_BASE, 29'h0600_0000, DDRAM 64-bit-word base address of the ROM area.
- REGION_SHIFT, 21, log2 of region size in 64-bit words (21 gives 16 MB per ioctl_index).
- NUM_REGIONS, 8, number of valid ioctl_index values (0..NUM_REGIONS-1).

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  27  byte address within file; bit 0 ignored.
- ioctl_dout  in  16  data word.
- ioctl_index  in  8  ROM region selector.
- ioctl_wait  out  1  stall request to HPS.
- ddram_busy  in  1  DDRAM not accepting.
- ddram_we  out  1  write request, held until accepted.
- ddram_addr  out  29  64-bit word address.
- ddram_din  out  64  write data.
- ddram_be  out  8  byte enables.
- load_done  out  1  one-cycle pulse after final write of a download is accepted.
- load_err  out  1  sticky error flag, cleared at download start.

Behaviour:
- Reset: ddram_we=0, ddram_addr=0, ddram_din=0, ddram_be=0, ioctl_wait=0, load_done=0, load_err=0; acc and out buffers empty; state IDLE. Reset during a held ddram_we drops it on the next edge; that write is abandoned.
- Lane mapping: lane = ioctl_addr[2:1]. Data goes to din[16*lane+15:16*lane]; be[2*lane+1:2*lane] is set. No byte swap.
- Word address: DDR_BASE + (ioctl_index[2:0] << REGION_SHIFT) + ioctl_addr[REGION_SHIFT+2:3]. Additions are modulo 2^29.
- Out-of-range writes: if ioctl_index >= NUM_REGIONS, or any ioctl_addr bit above REGION_SHIFT+2 is set, the write is dropped and load_err is set.
- Accumulator (acc): holds a word address, 64-bit data and 8-bit be.
  - A write whose word address matches acc merges into acc.
  - A write to a different word address while acc is non-empty moves acc to out and starts a fresh acc with the new write in the same cycle.
  - A write to lane 3 completes acc: acc moves to out on the next edge, including the new data.
- Out register: while valid, drives ddram_we=1 with stable addr/din/be.
  - Accepted on an edge where ddram_we && !ddram_busy; out becomes empty after that edge.
  - Latency: lane-3 write at cycle N gives ddram_we=1 at N+1; with busy low the accept edge ends cycle N+1.
- ioctl_wait: registered and equal to out valid. Upstream must not assert ioctl_wr while ioctl_wait=1. If it does, the write is dropped and load_err is set.
- State machine:
  - IDLE: on rising ioctl_download, clear load_err and go to LOAD.
  - LOAD: pack writes as above. On falling ioctl_download, go to DRAIN; a non-empty acc moves to out when out is empty (otherwise on the first cycle out frees).
  - DRAIN: wait until acc and out are both empty, then go to DONE.
  - DONE: load_done=1 for exactly one cycle, then IDLE.
- A rising ioctl_download while in DRAIN or DONE is honoured only after the return to IDLE. Its first write is stalled by ioctl_wait when out is occupied.
- A download with zero writes still produces load_done one cycle after DRAIN is entered.

Decomposition:
- Shared package pgm_pkg: DDR address width (29), DDR_BASE, region index constants (program ROM, tile, sprite A/B, sample ROM), lane/be width constants.
- One natural sub-module: pgm_word_packer, containing the acc buffer with merge/complete/flush logic.
- The FSM and out register stay in the top.

Test Plan:
- Index 0, addr 0,2,4,6 with data 1111,2222,3333,4444, busy=0 -> one write: addr=0600_0000, din=4444_3333_2222_1111, be=FF, ioctl_wait high for 1 cycle.
- Same as above with busy=1 for 5 cycles after ddram_we rises -> ddram_we/addr/din stable for 6 cycles, ioctl_wait high throughout, a single accept.
- Index 1, writes to addr 8 and A, then download falls -> write addr=0620_0001, be=0F, din[31:0]=data; load_done pulses once after accept.
- Writes to addr 0 then addr 10 (hex) -> two writes: word 0 be=03, then word 2 be=03, in order.
- Index 9 write, or addr bit 24 set with index 0 -> no ddram_we, load_err=1; load_err clears on next download start.
- Reset asserted while ddram_we=1 and busy=1 -> next cycle all outputs 0, state IDLE, no load_done.
